// File: rtl/pll_mdrp_pkg.sv
// Shared types, MDRP opcodes and the compiled-in preset table for the PLL reconfiguration sequencer.
// The verify states exist only when PLL_MDRP_VERIFY_EN is defined.
package pll_mdrp_pkg;

    localparam logic [1:0] MD_NOP  = 2'b00;
    localparam logic [1:0] MD_ADDR = 2'b11;
    localparam logic [1:0] MD_RD   = 2'b10;
    localparam logic [1:0] MD_WR   = 2'b01;

    localparam int unsigned TBL_MODES = 4;
    localparam int unsigned TBL_REGS  = 4;
    localparam int unsigned TBL_MW    = 2;
    localparam int unsigned TBL_IW    = 2;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] mask;
        logic [7:0] data;
    } preset_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_ADDR,
        ST_READ,
        ST_RD_WAIT,
        ST_WRITE,
`ifdef PLL_MDRP_VERIFY_EN
        ST_VADDR,
        ST_VREAD,
        ST_VWAIT,
        ST_VCHK,
`endif
        ST_NEXT,
        ST_RELEASE,
        ST_LOCK_WAIT,
        ST_ERR
    } state_t;

    // {addr, mask, data}; mode 0 mirrors the PLL power-up defparam configuration
    localparam logic [23:0] PRESET_TBL [TBL_MODES][TBL_REGS] = '{
        '{24'h12_0F_03, 24'h13_FF_2A, 24'h14_3F_11, 24'h15_C0_40},
        '{24'h12_0F_05, 24'h13_FF_1C, 24'h14_3F_21, 24'h15_C0_80},
        '{24'h12_0F_09, 24'h13_FF_14, 24'h14_3F_07, 24'h15_C0_00},
        '{24'h12_0F_03, 24'h13_FF_2A, 24'h14_3F_11, 24'h15_C0_40}
    };

    function automatic logic [7:0] md_merge(input logic [7:0] rdo, input preset_t e);
        return (rdo & ~e.mask) | (e.data & e.mask);
    endfunction

endpackage

// File: rtl/pll_mdrp_if.sv
// MDRP side-band bundle between the sequencer (master) and the PLL primitive (slave).
interface pll_mdrp_if;
    logic       pll_lock;
    logic       pll_reset;
    logic [1:0] md_opc;
    logic       md_ainc;
    logic [7:0] md_wdi;
    logic [7:0] md_rdo;

    modport master (input pll_lock, md_rdo, output pll_reset, md_opc, md_ainc, md_wdi);
    modport slave  (output pll_lock, md_rdo, input pll_reset, md_opc, md_ainc, md_wdi);
endinterface

// File: rtl/pll_mdrp_rom.sv
// Combinational preset lookup (mode, index) -> entry; boards swap presets by editing the package table.
module pll_mdrp_rom
    import pll_mdrp_pkg::*;
#(
    parameter int unsigned NUM_MODES = 2,
    parameter int unsigned NUM_REGS  = 4,
    localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [MW-1:0] mode,
    input  logic [IW-1:0] idx,
    output preset_t       entry_c
);

    always_comb begin
        entry_c = preset_t'(PRESET_TBL[TBL_MW'(mode)][TBL_IW'(idx)]);
    end

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// GW5A PLLA dynamic-reconfiguration sequencer: hold PLL in reset, read-modify-write presets, wait for lock.
// Define PLL_MDRP_VERIFY_EN to read back and check every register after it is written.
module pll_mdrp_ctrl
    import pll_mdrp_pkg::*;
#(
    parameter int unsigned NUM_MODES    = 2,
    parameter int unsigned NUM_REGS     = 4,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [MW-1:0] mode_sel,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [MW-1:0] cur_mode,
    pll_mdrp_if.master    md
);

    localparam int unsigned IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WMAX = (RST_CYCLES > RD_LAT) ? RST_CYCLES : RD_LAT;
    localparam int unsigned CW   = $clog2(WMAX + 1);
    localparam int unsigned TW   = $clog2(LOCK_TIMEOUT + 1);

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d, rom_idx_c;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [MW-1:0] mode_q, mode_d, cur_d;
    logic          busy_d, done_d, err_d, pll_rst_q, pll_rst_d;
    logic [1:0]    opc_q, opc_d;
    logic [7:0]    wdi_q, wdi_d;
    logic          lock_s1, lock_s2;
    preset_t       ent_c;
`ifdef PLL_MDRP_VERIFY_EN
    logic [7:0]    rdo_q, rdo_d;
`endif

    // ROM is addressed ahead of the index register so ADDR can present the next entry directly
    assign rom_idx_c = (state == ST_NEXT) ? idx + IW'(1) : idx;

    pll_mdrp_rom #(.NUM_MODES(NUM_MODES), .NUM_REGS(NUM_REGS)) u_rom (
        .mode    (mode_q),
        .idx     (rom_idx_c),
        .entry_c (ent_c)
    );

    assign md.pll_reset = pll_rst_q;
    assign md.md_opc    = opc_q;
    assign md.md_ainc   = 1'b0;
    assign md.md_wdi    = wdi_q;

    // Next-state and next-output decode
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        tmo_d     = tmo;
        mode_d    = mode_q;
        cur_d     = cur_mode;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = error;
        pll_rst_d = pll_rst_q;
        opc_d     = MD_NOP;
        wdi_d     = wdi_q;
`ifdef PLL_MDRP_VERIFY_EN
        rdo_d     = rdo_q;
`endif
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (32'(mode_sel) >= NUM_MODES) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (mode_sel == cur_mode && !error) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_RST_ASSERT;
                        err_d     = 1'b0;
                        busy_d    = 1'b1;
                        mode_d    = mode_sel;
                        idx_d     = '0;
                        cnt_d     = '0;
                        pll_rst_d = 1'b1;
                    end
                end
            end
            ST_RST_ASSERT: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    opc_d   = MD_ADDR;
                    wdi_d   = ent_c.addr;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_ADDR: begin
                state_d = ST_READ;
                opc_d   = MD_RD;
            end
            ST_READ: begin
                state_d = ST_RD_WAIT;
                cnt_d   = '0;
            end
            ST_RD_WAIT: begin
                if (cnt == CW'(RD_LAT - 1)) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                    opc_d   = MD_WR;
                    wdi_d   = md_merge(md.md_rdo, ent_c);
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef PLL_MDRP_VERIFY_EN
            ST_WRITE: begin
                state_d = ST_VADDR;
                opc_d   = MD_ADDR;
                wdi_d   = ent_c.addr;
            end
            ST_VADDR: begin
                state_d = ST_VREAD;
                opc_d   = MD_RD;
            end
            ST_VREAD: begin
                state_d = ST_VWAIT;
                cnt_d   = '0;
            end
            ST_VWAIT: begin
                if (cnt == CW'(RD_LAT - 1)) begin
                    state_d = ST_VCHK;
                    cnt_d   = '0;
                    rdo_d   = md.md_rdo;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_VCHK: begin
                // A failed check leaves the PLL held in reset
                if ((rdo_q & ent_c.mask) != (ent_c.data & ent_c.mask)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_NEXT;
                end
            end
`else
            ST_WRITE: begin
                state_d = ST_NEXT;
            end
`endif
            ST_NEXT: begin
                if (idx == IW'(NUM_REGS - 1)) begin
                    state_d   = ST_RELEASE;
                    pll_rst_d = 1'b0;
                    tmo_d     = '0;
                end else begin
                    state_d = ST_ADDR;
                    idx_d   = idx + IW'(1);
                    opc_d   = MD_ADDR;
                    wdi_d   = ent_c.addr;
                end
            end
            ST_RELEASE: begin
                state_d = ST_LOCK_WAIT;
                tmo_d   = '0;
            end
            ST_LOCK_WAIT: begin
                if (lock_s2) begin
                    state_d = ST_IDLE;
                    cur_d   = mode_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tmo >= TW'(LOCK_TIMEOUT)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo + TW'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, outputs and lock synchroniser
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            tmo       <= '0;
            mode_q    <= '0;
            cur_mode  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            pll_rst_q <= 1'b0;
            opc_q     <= MD_NOP;
            wdi_q     <= '0;
            lock_s1   <= 1'b0;
            lock_s2   <= 1'b0;
`ifdef PLL_MDRP_VERIFY_EN
            rdo_q     <= '0;
`endif
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            tmo       <= tmo_d;
            mode_q    <= mode_d;
            cur_mode  <= cur_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= err_d;
            pll_rst_q <= pll_rst_d;
            opc_q     <= opc_d;
            wdi_q     <= wdi_d;
            lock_s1   <= md.pll_lock;
            lock_s2   <= lock_s1;
`ifdef PLL_MDRP_VERIFY_EN
            rdo_q     <= rdo_d;
`endif
        end
    end

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Bench for pll_mdrp_ctrl: PLL register-file model, write scoreboard, lock/timeout/reset scenarios.
// The readback-corruption scenario runs only when PLL_MDRP_VERIFY_EN is defined.
module tb_pll_mdrp_ctrl;
    import pll_mdrp_pkg::*;

    localparam int unsigned NM = 3;
    localparam int unsigned NR = 4;

    // Independent copy of the expected preset contents {addr, mask, data}
    localparam logic [23:0] TB_TBL [3][4] = '{
        '{24'h12_0F_03, 24'h13_FF_2A, 24'h14_3F_11, 24'h15_C0_40},
        '{24'h12_0F_05, 24'h13_FF_1C, 24'h14_3F_21, 24'h15_C0_80},
        '{24'h12_0F_09, 24'h13_FF_14, 24'h14_3F_07, 24'h15_C0_00}
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic       busy, done, error;
    logic [1:0] cur_mode;

    pll_mdrp_if md_if ();

    pll_mdrp_ctrl #(
        .NUM_MODES    (NM),
        .NUM_REGS     (NR),
        .RD_LAT       (2),
        .RST_CYCLES   (16),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .mode_sel (mode_sel),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cur_mode (cur_mode),
        .md       (md_if)
    );

    always #5 clk = ~clk;

    // PLL model: register file, 2-cycle read pipe, lock 50 cycles after reset release
    logic [7:0] regs [256];
    logic [7:0] addr_m;
    logic [7:0] rp0;
    logic       model_init = 1'b0;
    int         lk_cnt;
    bit         lock_en = 1'b1;
    bit         corrupt = 1'b0;

    always @(posedge clk) begin
        if (!model_init) begin
            for (int a = 0; a < 256; a++) regs[a] <= 8'(a) ^ 8'h5A;
            regs[8'h12]      <= 8'hA3;
            model_init       <= 1'b1;
            addr_m           <= 8'h00;
            rp0              <= 8'h00;
            md_if.md_rdo     <= 8'h00;
            md_if.pll_lock   <= 1'b0;
            lk_cnt           <= 0;
        end else begin
            case (md_if.md_opc)
                MD_ADDR: addr_m <= md_if.md_wdi;
                MD_RD:   rp0 <= regs[addr_m];
                MD_WR:   regs[addr_m] <= md_if.md_wdi;
                default: ;
            endcase
            md_if.md_rdo <= rp0 ^ {7'd0, corrupt};
            if (md_if.pll_reset || !lock_en) begin
                lk_cnt         <= 0;
                md_if.pll_lock <= 1'b0;
            end else if (lk_cnt >= 49) begin
                md_if.pll_lock <= 1'b1;
            end else begin
                lk_cnt <= lk_cnt + 1;
            end
        end
    end

    int total = 0;
    int bad = 0;
    int wr_seen = 0, done_cnt = 0, nonnop = 0, rst_hi = 0, cyc = 0;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle; monitors the DUT on the falling edge and pops the scoreboard on every write
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        if (md_if.md_opc == MD_WR) begin
            wr_seen++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_wr", 32'(md_if.md_wdi), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(addr_m), 32'(e[15:8]));
                chk("wr_data", 32'(md_if.md_wdi), 32'(e[7:0]));
            end
        end
        if (md_if.md_opc != MD_NOP) nonnop++;
        if (done) done_cnt++;
        if (md_if.pll_reset) rst_hi++;
    endtask

    task automatic push_entry(input int m, input int i);
        logic [23:0] e;
        logic [7:0]  a, mk, dt;
        e  = TB_TBL[m][i];
        a  = e[23:16];
        mk = e[15:8];
        dt = e[7:0];
        sb.push_back({a, (regs[a] & ~mk) | (dt & mk)});
    endtask

    task automatic push_mode(input int m);
        for (int i = 0; i < int'(NR); i++) push_entry(m, i);
    endtask

    task automatic start(input logic [1:0] m);
        mode_sel = m;
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!done && !error && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk(tag, 32'(n), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_cur"}, 32'(cur_mode), 0);
        chk({tag, "_pllrst"}, 32'(md_if.pll_reset), 0);
        chk({tag, "_opc"}, 32'(md_if.md_opc), 0);
        chk({tag, "_ainc"}, 32'(md_if.md_ainc), 0);
        chk({tag, "_wdi"}, 32'(md_if.md_wdi), 0);
    endtask

    initial begin
        int b_done, b_rst, b_wr, b_nn, t0, n;
        bit prev, hit;

        repeat (3) tick();
        chk_reset_vals("por");
        reset = 1'b0;
        tick();

        // Full reconfiguration to mode 1
        push_mode(1);
        b_done = done_cnt; b_rst = rst_hi; b_wr = wr_seen;
        start(2'd1);
        chk("m1_acc_pllrst", 32'(md_if.pll_reset), 1);
        chk("m1_acc_busy", 32'(busy), 1);
        wait_end("m1_bound");
        chk("m1_done", 32'(done), 1);
        chk("m1_cur", 32'(cur_mode), 1);
        chk("m1_busy", 32'(busy), 0);
        chk("m1_err", 32'(error), 0);
        chk("m1_rst_hi_ge16", 32'((rst_hi - b_rst) >= 16), 1);
        chk("m1_wr_cnt", 32'(wr_seen - b_wr), 4);
        chk("m1_sb_left", 32'(sb.size()), 0);
        chk("m1_reg12", 32'(regs[8'h12]), 32'hA5);
        tick();
        chk("m1_done_pulse", 32'(done), 0);
        chk("m1_done_cnt", 32'(done_cnt - b_done), 1);

        // Same mode again: immediate done, no PLL traffic
        b_nn = nonnop; b_done = done_cnt;
        start(2'd1);
        chk("same_done", 32'(done), 1);
        chk("same_busy", 32'(busy), 0);
        repeat (4) tick();
        chk("same_opc_nop", 32'(nonnop - b_nn), 0);
        chk("same_pllrst", 32'(md_if.pll_reset), 0);
        chk("same_done_cnt", 32'(done_cnt - b_done), 1);

        // Lock never arrives: timeout error
        lock_en = 1'b0;
        push_mode(2);
        b_done = done_cnt;
        start(2'd2);
        prev = md_if.pll_reset;
        t0 = -1000;
        n = 0;
        while (!error && n < 400) begin
            tick();
            n++;
            if (prev && !md_if.pll_reset) t0 = cyc;
            prev = md_if.pll_reset;
        end
        chk("to_error", 32'(error), 1);
        chk("to_lat_lo", 32'((cyc - t0) >= 100), 1);
        chk("to_lat_hi", 32'((cyc - t0) <= 104), 1);
        chk("to_cur", 32'(cur_mode), 1);
        chk("to_done_cnt", 32'(done_cnt - b_done), 0);
        chk("to_sb_left", 32'(sb.size()), 0);
        tick();
        chk("to_sticky", 32'(error), 1);

        // Next valid request clears error and completes
        lock_en = 1'b1;
        push_mode(2);
        start(2'd2);
        chk("clr_error", 32'(error), 0);
        wait_end("m2_bound");
        chk("m2_done", 32'(done), 1);
        chk("m2_cur", 32'(cur_mode), 2);
        tick();

        // Out-of-range mode
        b_nn = nonnop;
        start(2'd3);
        chk("bad_error", 32'(error), 1);
        chk("bad_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("bad_opc_nop", 32'(nonnop - b_nn), 0);
        chk("bad_sticky", 32'(error), 1);
        chk("bad_cur", 32'(cur_mode), 2);
        chk("bad_pllrst", 32'(md_if.pll_reset), 0);

        // Reset pulsed during the second WRITE
        push_mode(0);
        b_wr = wr_seen;
        start(2'd0);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 400) begin
            tick();
            n++;
            if (md_if.md_opc == MD_WR && (wr_seen - b_wr) == 2) hit = 1'b1;
        end
        chk("rm_hit", 32'(hit), 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("rm");
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        push_mode(1);
        start(2'd1);
        wait_end("rm_bound");
        chk("rm_done", 32'(done), 1);
        chk("rm_cur", 32'(cur_mode), 1);
        chk("rm_sb_left", 32'(sb.size()), 0);
        tick();

`ifdef PLL_MDRP_VERIFY_EN
        // Corrupted readback: stop after first register, PLL kept in reset
        corrupt = 1'b1;
        push_entry(2, 0);
        b_done = done_cnt; b_wr = wr_seen;
        start(2'd2);
        wait_end("v_bound");
        chk("v_error", 32'(error), 1);
        chk("v_pllrst", 32'(md_if.pll_reset), 1);
        chk("v_wr_cnt", 32'(wr_seen - b_wr), 1);
        chk("v_sb_left", 32'(sb.size()), 0);
        repeat (3) tick();
        chk("v_pllrst_hold", 32'(md_if.pll_reset), 1);
        chk("v_done_cnt", 32'(done_cnt - b_done), 0);
        chk("v_cur", 32'(cur_mode), 1);
        corrupt = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
